// File: rtl/spi_master_arbiter.sv
// Two-requester SPI master with round-robin arbitration.
// Mode: SCLK idles low, MISO captured on rising SCLK, MOSI updated on falling SCLK, MSB first.
// Every output is a register, so no input reaches an output combinationally.
module spi_master_arbiter #(
  parameter int DATA_W   = 8,
  parameter int CLK_HALF = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] tx_data0,
  input  logic [DATA_W-1:0] tx_data1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic [1:0]        select,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int TGL_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HALF - 1);
  localparam logic [TGL_W-1:0] TGL_LAST = TGL_W'(2 * DATA_W);
  localparam logic [TGL_W-1:0] TGL_PREV = TGL_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic              grant;
  logic              last_served;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  half_cnt;
  logic [TGL_W-1:0]  toggles;
  logic              half_end;
  logic              pick;

  // A half-period has elapsed when the counter reaches its last value.
  assign half_end = (half_cnt == CNT_LAST);

  // Round-robin choice: a lone requester wins; with both active the one not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = ~last_served;
    end else begin
      pick = req[1];
    end
  end

  // Transfer FSM: grant, select setup, SCLK toggling with shift/capture, then a one-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_served <= 1'b1;
      tx_shift    <= '0;
      rx_shift    <= '0;
      half_cnt    <= '0;
      toggles     <= '0;
      sclk        <= 1'b0;
      select      <= 2'b00;
      mosi        <= 1'b0;
      done        <= 2'b00;
      busy        <= 1'b0;
      rx_data     <= '0;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant    <= pick;
            tx_shift <= pick ? tx_data1 : tx_data0;
            mosi     <= pick ? tx_data1[DATA_W-1] : tx_data0[DATA_W-1];
            select   <= pick ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            half_cnt <= '0;
            toggles  <= '0;
            rx_shift <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            // First rising edge: it also captures the first MISO bit.
            half_cnt <= '0;
            sclk     <= 1'b1;
            toggles  <= TGL_W'(1);
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            half_cnt <= '0;
            if (toggles == TGL_LAST) begin
              // SCLK has been low for a full half-period after the last fall: close out.
              state       <= DONE;
              select      <= 2'b00;
              mosi        <= 1'b0;
              done        <= grant ? 2'b10 : 2'b01;
              rx_data     <= rx_shift;
              last_served <= grant;
            end else begin
              sclk    <= ~sclk;
              toggles <= toggles + 1'b1;
              if (!sclk) begin
                rx_shift <= {rx_shift[DATA_W-2:0], miso};
              end else if (toggles != TGL_PREV) begin
                tx_shift <= tx_shift << 1;
                mosi     <= tx_shift[DATA_W-2];
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench: two DUTs (CLK_HALF=2 and CLK_HALF=1) compared every cycle
// against a transaction-level model, plus directed transfers with literal expectations.
module tb_spi_master_arbiter;

  localparam int DW = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_a      [2];
  logic [7:0] tx0_a      [2];
  logic [7:0] tx1_a      [2];
  logic       loop_cfg   [2];
  logic [7:0] resp_cfg   [2];
  logic       slv_bit    [2];
  logic [1:0] done_a     [2];
  logic [7:0] rx_data_a  [2];
  logic       busy_a     [2];
  logic       sclk_a     [2];
  logic [1:0] sel_a      [2];
  logic       mosi_a     [2];

  // Model state per instance: active transfer, cycle offset since grant, latched values.
  logic       m_act      [2];
  int         m_k        [2];
  logic       m_g        [2];
  logic       m_last     [2];
  logic [7:0] m_tx       [2];
  logic [7:0] m_rxe      [2];
  logic [7:0] m_resp     [2];
  logic [7:0] m_rx_hold  [2];

  int n_cmp = 0;
  int n_bad = 0;

  spi_master_arbiter #(.DATA_W(DW), .CLK_HALF(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_a[0]), .tx_data0(tx0_a[0]), .tx_data1(tx1_a[0]),
    .done(done_a[0]), .rx_data(rx_data_a[0]), .busy(busy_a[0]), .sclk(sclk_a[0]),
    .select(sel_a[0]), .mosi(mosi_a[0]), .miso(loop_cfg[0] ? mosi_a[0] : slv_bit[0])
  );

  spi_master_arbiter #(.DATA_W(DW), .CLK_HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_a[1]), .tx_data0(tx0_a[1]), .tx_data1(tx1_a[1]),
    .done(done_a[1]), .rx_data(rx_data_a[1]), .busy(busy_a[1]), .sclk(sclk_a[1]),
    .select(sel_a[1]), .mosi(mosi_a[1]), .miso(loop_cfg[1] ? mosi_a[1] : slv_bit[1])
  );

  // Free-running system clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ch_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int xfer_len(input int i);
    return (2 * DW + 1) * ch_of(i);
  endfunction

  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    return (r == 2'b11) ? ~last : r[1];
  endfunction

  // Transaction model: a grant starts an offset count; the transfer retires one cycle after done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]     <= 1'b0;
        m_k[i]       <= 0;
        m_g[i]       <= 1'b0;
        m_last[i]    <= 1'b1;
        m_tx[i]      <= '0;
        m_rxe[i]     <= '0;
        m_resp[i]    <= '0;
        m_rx_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (m_k[i] == xfer_len(i) + 1) begin
            m_act[i]     <= 1'b0;
            m_last[i]    <= m_g[i];
            m_rx_hold[i] <= m_rxe[i];
          end else begin
            m_k[i] <= m_k[i] + 1;
          end
        end else if (req_a[i] != 2'b00) begin
          m_g[i]    <= rr_pick(req_a[i], m_last[i]);
          m_tx[i]   <= rr_pick(req_a[i], m_last[i]) ? tx1_a[i] : tx0_a[i];
          m_rxe[i]  <= loop_cfg[i] ? (rr_pick(req_a[i], m_last[i]) ? tx1_a[i] : tx0_a[i])
                                   : resp_cfg[i];
          m_resp[i] <= resp_cfg[i];
          m_k[i]    <= 1;
          m_act[i]  <= 1'b1;
        end
      end
    end
  end

  task automatic check_output(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s (dut%0d) at %0t: got 0x%0h, want 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Derive every expected output from the model's offset and compare; also drive the slave MISO bit.
  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int         k;
      int         ph;
      int         idx;
      logic       e_sclk;
      logic       e_mosi;
      logic       e_busy;
      logic       s_bit;
      logic [1:0] e_sel;
      logic [1:0] e_done;
      logic [7:0] e_rx;
      e_sclk = 1'b0;
      e_mosi = 1'b0;
      e_busy = 1'b0;
      s_bit  = 1'b0;
      e_sel  = 2'b00;
      e_done = 2'b00;
      e_rx   = 8'h00;
      if (rst_n) begin
        e_rx = m_rx_hold[i];
        if (m_act[i]) begin
          k = m_k[i];
          if (k >= 1 && k <= xfer_len(i)) begin
            ph     = (k - 1) / ch_of(i);
            idx    = (ph / 2 > DW - 1) ? DW - 1 : ph / 2;
            e_busy = 1'b1;
            e_sel  = m_g[i] ? 2'b10 : 2'b01;
            e_sclk = (ph >= 1) && (ph <= 2 * DW) && (ph % 2 == 1);
            e_mosi = m_tx[i][DW-1-idx];
            s_bit  = m_resp[i][DW-1-idx];
          end else begin
            e_busy = 1'b1;
            e_done = m_g[i] ? 2'b10 : 2'b01;
            e_rx   = m_rxe[i];
          end
        end
      end
      slv_bit[i] = s_bit;
      check_output("sclk", i, sclk_a[i], e_sclk);
      check_output("select", i, sel_a[i], e_sel);
      check_output("mosi", i, mosi_a[i], e_mosi);
      check_output("done", i, done_a[i], e_done);
      check_output("busy", i, busy_a[i], e_busy);
      check_output("rx_data", i, rx_data_a[i], e_rx);
    end
  endtask

  // One cycle: compare at the falling edge, then leave a small gap before new stimulus.
  task automatic tick();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic apply_stimulus(input int inst, input logic [1:0] r, input logic [7:0] d0,
                                input logic [7:0] d1, input logic lp, input logic [7:0] rsp);
    req_a[inst]    = r;
    tx0_a[inst]    = d0;
    tx1_a[inst]    = d1;
    loop_cfg[inst] = lp;
    resp_cfg[inst] = rsp;
  endtask

  // Follow one transfer, dropping req and/or rewriting tx_data0 at given cycle offsets.
  task automatic run_xfer(input int inst, input int drop_n, input int chg_n, input logic [7:0] chg_v,
                          output int sel_cnt, output int rises, output logic [7:0] mbits,
                          output logic [1:0] sel_or, output int done_n,
                          output logic [1:0] done_v, output logic [7:0] rx_v);
    logic prev_sclk;
    prev_sclk = 1'b0;
    sel_cnt   = 0;
    rises     = 0;
    mbits     = 8'h00;
    sel_or    = 2'b00;
    done_n    = -1;
    done_v    = 2'b00;
    rx_v      = 8'h00;
    for (int n = 1; n <= 80 && done_n < 0; n++) begin
      tick();
      if (n == drop_n) req_a[inst] = 2'b00;
      if (n == chg_n) tx0_a[inst] = chg_v;
      if (sel_a[inst] != 2'b00) sel_cnt++;
      sel_or = sel_or | sel_a[inst];
      if (sclk_a[inst] && !prev_sclk) begin
        rises++;
        mbits = {mbits[6:0], mosi_a[inst]};
      end
      prev_sclk = sclk_a[inst];
      if (done_a[inst] != 2'b00) begin
        done_n = n;
        done_v = done_a[inst];
        rx_v   = rx_data_a[inst];
      end
    end
  endtask

  initial begin
    int         sel_cnt;
    int         rises;
    int         done_n;
    int         nd;
    int         gap;
    logic [7:0] mbits;
    logic [7:0] rx_v;
    logic [1:0] sel_or;
    logic [1:0] done_v;

    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(i, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00);
      slv_bit[i] = 1'b0;
    end
    #1 rst_n = 1'b0;

    $display("[TB] reset state and round-robin with both requesters held");
    apply_stimulus(0, 2'b11, 8'h11, 8'h22, 1'b1, 8'h00);
    repeat (3) tick();
    check_output("rst_busy", 0, busy_a[0], 1'b0);
    check_output("rst_select", 0, sel_a[0], 2'b00);
    check_output("rst_sclk", 0, sclk_a[0], 1'b0);
    check_output("rst_rx", 0, rx_data_a[0], 8'h00);
    rst_n = 1'b1;
    nd  = 0;
    gap = 0;
    for (int n = 1; n <= 200 && nd < 4; n++) begin
      tick();
      if (sel_a[0] != 2'b00) begin
        if (nd > 0 && gap > 0) check_output("t3_gap", 0, gap, 2);
        gap = 0;
      end else begin
        gap++;
      end
      if (done_a[0] != 2'b00) begin
        check_output("t3_grant", 0, done_a[0], (nd % 2 == 0) ? 2'b01 : 2'b10);
        check_output("t3_rx", 0, rx_data_a[0], (nd % 2 == 0) ? 8'h11 : 8'h22);
        nd++;
      end
    end
    check_output("t3_count", 0, nd, 4);
    req_a[0] = 2'b00;
    repeat (4) tick();

    $display("[TB] loopback 0xA5 from requester 0");
    apply_stimulus(0, 2'b01, 8'hA5, 8'h00, 1'b1, 8'h00);
    run_xfer(0, 1, -1, 8'h00, sel_cnt, rises, mbits, sel_or, done_n, done_v, rx_v);
    check_output("t1_done_cycle", 0, done_n, 35);
    check_output("t1_done", 0, done_v, 2'b01);
    check_output("t1_rx", 0, rx_v, 8'hA5);
    check_output("t1_sel_cycles", 0, sel_cnt, 34);
    check_output("t1_rises", 0, rises, 8);
    check_output("t1_mosi_bits", 0, mbits, 8'hA5);
    tick();
    check_output("t1_busy_after", 0, busy_a[0], 1'b0);
    repeat (3) tick();

    $display("[TB] reset in the middle of a transfer");
    apply_stimulus(0, 2'b01, 8'h5A, 8'h00, 1'b1, 8'h00);
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 1) req_a[0] = 2'b00;
    end
    check_output("t4_sclk_high", 0, sclk_a[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("t4_sclk", 0, sclk_a[0], 1'b0);
    check_output("t4_select", 0, sel_a[0], 2'b00);
    check_output("t4_busy", 0, busy_a[0], 1'b0);
    check_output("t4_rx", 0, rx_data_a[0], 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    apply_stimulus(0, 2'b11, 8'hC3, 8'h3C, 1'b1, 8'h00);
    run_xfer(0, 1, -1, 8'h00, sel_cnt, rises, mbits, sel_or, done_n, done_v, rx_v);
    check_output("t4_done_cycle", 0, done_n, 35);
    check_output("t4_done", 0, done_v, 2'b01);
    check_output("t4_rx_after", 0, rx_v, 8'hC3);
    repeat (3) tick();

    $display("[TB] slave returns 0x3C to requester 1");
    apply_stimulus(0, 2'b10, 8'h00, 8'h81, 1'b0, 8'h3C);
    run_xfer(0, 1, -1, 8'h00, sel_cnt, rises, mbits, sel_or, done_n, done_v, rx_v);
    check_output("t2_mosi_bits", 0, mbits, 8'h81);
    check_output("t2_rx", 0, rx_v, 8'h3C);
    check_output("t2_done", 0, done_v, 2'b10);
    check_output("t2_sel0_never", 0, sel_or[0], 1'b0);
    check_output("t2_done_cycle", 0, done_n, 35);
    repeat (3) tick();

    $display("[TB] CLK_HALF=1 with early req drop and late tx_data change");
    apply_stimulus(1, 2'b01, 8'hF0, 8'h00, 1'b1, 8'h00);
    run_xfer(1, 3, 2, 8'h0F, sel_cnt, rises, mbits, sel_or, done_n, done_v, rx_v);
    check_output("t5_done_cycle", 1, done_n, 18);
    check_output("t5_done", 1, done_v, 2'b01);
    check_output("t5_mosi_bits", 1, mbits, 8'hF0);
    check_output("t5_rx", 1, rx_v, 8'hF0);
    check_output("t5_sel_cycles", 1, sel_cnt, 17);
    check_output("t5_rises", 1, rises, 8);
    repeat (3) tick();

    $display("[TB] randomized traffic on both instances");
    loop_cfg[0] = 1'b0;
    loop_cfg[1] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(5) == 0) req_a[i] = 2'($urandom_range(3));
        if ($urandom_range(2) == 0) tx0_a[i] = 8'($urandom);
        if ($urandom_range(2) == 0) tx1_a[i] = 8'($urandom);
        resp_cfg[i] = 8'($urandom);
      end
      if ($urandom_range(699) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Two-requester SPI master that shares one serial bus between two 8-bit slave endpoints. It arbitrates round-robin between requesters and generates SCLK from the system clock. It drives the active-high per-slave select, shifts MSB-first on MOSI and captures MISO into a receive byte. Each requester sees a simple req/done handshake; the block sits between bus-side logic and the slave shift registers.

Parameters:
DATA_W, 8, transfer width in bits; shift length and data port widths.
CLK_HALF, 2, SCLK half-period in clk cycles; legal range is 1 or greater.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  2  per-requester transfer request; level, held until done.
tx_data0  input  DATA_W  byte to send for requester 0.
tx_data1  input  DATA_W  byte to send for requester 1.
done  output  2  one-cycle pulse to the granted requester at transfer end.
rx_data  output  DATA_W  byte captured from MISO; valid when done pulses, held until next done.
busy  output  1  high in every state except IDLE.
sclk  output  1  serial clock; idles low.
select  output  2  active-high slave select, one-hot or zero; select[i] serves requester i.
mosi  output  1  serial data out, MSB first.
miso  input  1  serial data in.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sclk=0, select=0, mosi=0, done=0, busy=0, rx_data=0, last-served pointer=1 so requester 0 wins first.
- All outputs are registered; no combinational path from any input to any output.
- Mode: SCLK idles low. MISO is sampled when sclk is registered high (rising). MOSI updates when sclk is registered low (falling). Bit DATA_W-1 is presented before the first rising edge.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE:
  - If any req bit is high, grant by round-robin. If only one is requesting, grant it. If both are requesting, grant the one not served last.
  - Latch the selected tx_data into the tx shift register and record grant g. Go to SETUP.
  - req changes in other states are ignored.
- SETUP:
  - select[g]=1 and mosi=tx[DATA_W-1] from the first SETUP cycle.
  - Half-period counter runs CLK_HALF cycles. Then sclk goes to 1 (toggle 1) and the state becomes SHIFT.
- SHIFT:
  - sclk toggles every CLK_HALF cycles, for 2*DATA_W toggles total counting from toggle 1.
  - Rising toggle: rx_shift = {rx_shift[DATA_W-2:0], miso}, using the miso value at that clk edge.
  - Falling toggle, except the last: shift tx left and drive the new MSB on mosi.
  - On the last falling toggle (sclk back to 0), go to DONE.
- DONE (exactly one cycle):
  - select=0, done[g]=1, rx_data=rx_shift, mosi=0.
  - Update last-served to g. Go to IDLE.
- Latency: with req sampled in IDLE at cycle T:
  - select high for cycles T+1 .. T+(2*DATA_W+1)*CLK_HALF.
  - done at cycle T+(2*DATA_W+1)*CLK_HALF+1.
  - For the defaults, select is high at T+1..T+34 and done is at T+35.
- Back-to-back: if req is still high after done, the next grant is taken in the following IDLE cycle. Select is low for at least 2 cycles (DONE + IDLE) between transfers.
- Requester deasserting req mid-transfer: the transfer still completes and done still pulses.
- tx_data changes after the grant have no effect on the current transfer.
- Reset asserted mid-transfer: select, sclk and busy drop immediately (async); rx_data is cleared and no done pulse is issued.
- Never more than one select bit high, never both done bits high, and done is never high outside DONE.

Test Plan:
1. Loopback (miso=mosi), req=01, tx_data0=0xA5, CLK_HALF=2 -> select=01 for 34 cycles, 8 sclk pulses, done=01 at T+35, rx_data=0xA5, busy low after.
2. Behavioural slave model returning 0x3C, req=10, tx_data1=0x81 -> mosi bit sequence 1,0,0,0,0,0,0,1 observed at sclk rises, rx_data=0x3C, done=10, select[0] never high.
3. req=11 held from reset, tx_data0=0x11, tx_data1=0x22, loopback -> grants alternate 0,1,0,1; rx_data sequence 0x11,0x22,0x11,0x22; select low for exactly 2 cycles between transfers.
4. rst_n pulsed low at cycle 10 of a transfer -> sclk=0, select=0, busy=0 the same cycle; no done. After release, a new req=01 completes normally, with requester 0 given priority.
5. CLK_HALF=1, req=01 dropped after 3 cycles, tx_data0=0xF0 changed to 0x0F at cycle 2 -> sclk toggles every cycle, transfer completes with 0xF0 on mosi, done at T+18.
